// File: rtl/traffic_sequencer_if.sv
// Handshake bundle for traffic_sequencer: advance/pedestrian inputs, phase and light outputs.
// master drives the strobes and observes the lights; slave is the sequencer itself.
interface traffic_sequencer_if #(
    parameter int unsigned CNT_W = 6
);
    logic             i_tick;
    logic             i_ped;
    logic [CNT_W-1:0] o_counter;
    logic [2:0]       o_main_light;
    logic [2:0]       o_side_light;
    logic             o_walk;
    logic             o_phase_chg;

    modport master (
        output i_tick,
        output i_ped,
        input  o_counter,
        input  o_main_light,
        input  o_side_light,
        input  o_walk,
        input  o_phase_chg
    );

    modport slave (
        input  i_tick,
        input  i_ped,
        output o_counter,
        output o_main_light,
        output o_side_light,
        output o_walk,
        output o_phase_chg
    );
endinterface

// File: rtl/traffic_sequencer.sv
// Phase counter and main/side light sequencer for the intersection controller.
// Optional pedestrian walk logic is enabled by defining TRAFFIC_PED_WALK_EN.
module traffic_sequencer #(
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned T_MY    = 15,
    parameter int unsigned T_AR1   = 17,
    parameter int unsigned T_SG    = 19,
    parameter int unsigned T_SY    = 27,
    parameter int unsigned T_AR2   = 29,
    parameter int unsigned T_CYCLE = 30
) (
    input logic               clk,
    input logic               rst,
    traffic_sequencer_if.slave bus
);

    if (!(T_MY > 0 && T_MY < T_AR1 && T_AR1 < T_SG && T_SG < T_SY &&
          T_SY < T_AR2 && T_AR2 < T_CYCLE && 64'(T_CYCLE) <= (64'd1 << CNT_W)))
    begin : g_bad_params
        $error("traffic_sequencer: phase boundaries must be strictly increasing and fit in CNT_W");
    end

    typedef enum logic [2:0] {
        ST_MG,
        ST_MY,
        ST_AR1,
        ST_SG,
        ST_SY,
        ST_AR2
    } state_t;

    localparam logic [CNT_W-1:0] LP_MY   = CNT_W'(T_MY);
    localparam logic [CNT_W-1:0] LP_AR1  = CNT_W'(T_AR1);
    localparam logic [CNT_W-1:0] LP_SG   = CNT_W'(T_SG);
    localparam logic [CNT_W-1:0] LP_SY   = CNT_W'(T_SY);
    localparam logic [CNT_W-1:0] LP_AR2  = CNT_W'(T_AR2);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(T_CYCLE - 1);

    logic [CNT_W-1:0] r_counter;
    state_t           r_state;
    logic [2:0]       r_main_light;
    logic [2:0]       r_side_light;
    logic             r_phase_chg;
    logic             r_walk;

    logic [CNT_W-1:0] w_cnt_nxt;
    state_t           w_state_nxt;
    logic [2:0]       w_main_nxt;
    logic [2:0]       w_side_nxt;

    always_comb begin
        w_cnt_nxt = r_counter;
        if (bus.i_tick) begin
            w_cnt_nxt = (r_counter == LP_LAST) ? '0 : r_counter + 1'b1;
        end
    end

    // State is a pure range decode of the next count, so it can never drift from the counter.
    always_comb begin
        if (w_cnt_nxt < LP_MY)       w_state_nxt = ST_MG;
        else if (w_cnt_nxt < LP_AR1) w_state_nxt = ST_MY;
        else if (w_cnt_nxt < LP_SG)  w_state_nxt = ST_AR1;
        else if (w_cnt_nxt < LP_SY)  w_state_nxt = ST_SG;
        else if (w_cnt_nxt < LP_AR2) w_state_nxt = ST_SY;
        else                         w_state_nxt = ST_AR2;
    end

    always_comb begin
        w_main_nxt = 3'b100;
        w_side_nxt = 3'b100;
        case (w_state_nxt)
            ST_MG:   w_main_nxt = 3'b001;
            ST_MY:   w_main_nxt = 3'b010;
            ST_SG:   w_side_nxt = 3'b001;
            ST_SY:   w_side_nxt = 3'b010;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_counter    <= '0;
            r_state      <= ST_MG;
            r_main_light <= 3'b001;
            r_side_light <= 3'b100;
            r_phase_chg  <= 1'b0;
        end else begin
            r_counter    <= w_cnt_nxt;
            r_state      <= w_state_nxt;
            r_main_light <= w_main_nxt;
            r_side_light <= w_side_nxt;
            r_phase_chg  <= (w_state_nxt != r_state);
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    logic r_ped_pending;
    logic w_enter_sg;
    logic w_leave_sg;

    assign w_enter_sg = (w_state_nxt == ST_SG) && (r_state != ST_SG);
    assign w_leave_sg = (r_state == ST_SG) && (w_state_nxt != ST_SG);

    // A request coincident with the SIDE_GREEN entry edge is served directly, never left pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ped_pending <= 1'b0;
            r_walk        <= 1'b0;
        end else if (w_enter_sg) begin
            r_walk        <= r_ped_pending | bus.i_ped;
            r_ped_pending <= 1'b0;
        end else begin
            if (w_leave_sg) r_walk <= 1'b0;
            r_ped_pending <= r_ped_pending | bus.i_ped;
        end
    end
`else
    logic w_unused_ped;
    assign w_unused_ped = bus.i_ped;
    assign r_walk       = 1'b0;
`endif

    assign bus.o_counter    = r_counter;
    assign bus.o_main_light = r_main_light;
    assign bus.o_side_light = r_side_light;
    assign bus.o_walk       = r_walk;
    assign bus.o_phase_chg  = r_phase_chg;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed self-checking bench for traffic_sequencer; walk checks follow TRAFFIC_PED_WALK_EN.
module tb_traffic_sequencer;

    localparam int unsigned CNT_W = 6;

    logic clk;
    logic rst;

    traffic_sequencer_if #(.CNT_W(CNT_W)) bus ();

    traffic_sequencer #(
        .CNT_W  (CNT_W),
        .T_MY   (15),
        .T_AR1  (17),
        .T_SG   (19),
        .T_SY   (27),
        .T_AR2  (29),
        .T_CYCLE(30)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference expectations kept by the bench.
    int m_cnt  = 0;
    int m_st   = 0;
    int m_pc   = 0;
    int m_walk = 0;
    int m_pend = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // 0=MG 1=MY 2=AR1 3=SG 4=SY 5=AR2
    function automatic int st_of(input int c);
        if (c < 15)      return 0;
        else if (c < 17) return 1;
        else if (c < 19) return 2;
        else if (c < 27) return 3;
        else if (c < 29) return 4;
        else             return 5;
    endfunction

    function automatic logic [31:0] main_of(input int s);
        case (s)
            0:       return 32'b001;
            1:       return 32'b010;
            default: return 32'b100;
        endcase
    endfunction

    function automatic logic [31:0] side_of(input int s);
        case (s)
            3:       return 32'b001;
            4:       return 32'b010;
            default: return 32'b100;
        endcase
    endfunction

    task automatic check_outputs(input string pfx);
        check({pfx, "_cnt"},   32'(bus.o_counter), 32'(m_cnt));
        check({pfx, "_main"},  32'(bus.o_main_light), main_of(m_st));
        check({pfx, "_side"},  32'(bus.o_side_light), side_of(m_st));
        check({pfx, "_pchg"},  32'(bus.o_phase_chg), 32'(m_pc));
        check({pfx, "_walk"},  32'(bus.o_walk), 32'(m_walk));
        check({pfx, "_excl"},  32'((bus.o_main_light != 3'b100) && (bus.o_side_light != 3'b100)), 32'd0);
    endtask

    task automatic step(input logic t, input logic p, input string pfx);
        int old_st;
        int new_st;
        bus.i_tick = t;
        bus.i_ped  = p;
        @(posedge clk);
        #1;
        old_st = m_st;
        if (t) m_cnt = (m_cnt == 29) ? 0 : m_cnt + 1;
        new_st = st_of(m_cnt);
        m_pc   = (new_st != old_st) ? 1 : 0;
`ifdef TRAFFIC_PED_WALK_EN
        if (new_st == 3 && old_st != 3) begin
            m_walk = (m_pend != 0 || p) ? 1 : 0;
            m_pend = 0;
        end else begin
            if (old_st == 3 && new_st != 3) m_walk = 0;
            if (p) m_pend = 1;
        end
`endif
        m_st = new_st;
        bus.i_tick = 1'b0;
        bus.i_ped  = 1'b0;
        check_outputs(pfx);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_st   = 0;
        m_pc   = 0;
        m_walk = 0;
        m_pend = 0;
    endtask

    int pulses;

    initial begin
        bus.i_tick = 1'b0;
        bus.i_ped  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_outputs("rst");
        rst = 1'b0;

        // Continuous ticks: two full cycles, 12 phase changes.
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b0, "run");
            if (bus.o_phase_chg) pulses++;
            check("run_lt30", 32'(bus.o_counter < 6'd30), 32'd1);
        end
        check("run_pulses", 32'(pulses), 32'd12);
        check("run_end_cnt", 32'(bus.o_counter), 32'd0);

        // Ticks every third clock: values hold between ticks.
        pulses = 0;
        for (int i = 0; i < 180; i++) begin
            step((i % 3) == 2, 1'b0, "slow");
            if (bus.o_phase_chg) pulses++;
        end
        check("slow_pulses", 32'(pulses), 32'd12);

        // Advance to count 22 then assert reset asynchronously mid-cycle.
        for (int i = 0; i < 22; i++) step(1'b1, 1'b0, "pre");
        check("pre_cnt22", 32'(bus.o_counter), 32'd22);
        check("pre_sg", 32'(bus.o_side_light), 32'b001);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_cnt",  32'(bus.o_counter), 32'd0);
        check("arst_main", 32'(bus.o_main_light), 32'b001);
        check("arst_side", 32'(bus.o_side_light), 32'b100);
        check("arst_walk", 32'(bus.o_walk), 32'd0);
        check("arst_pchg", 32'(bus.o_phase_chg), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 1'b0, "rel");
        step(1'b1, 1'b0, "rel");
        check("rel_cnt", 32'(bus.o_counter), 32'd1);

        // Explicit wrap from 29 to 0.
        for (int i = 1; i < 29; i++) step(1'b1, 1'b0, "towrap");
        check("wrap_at29", 32'(bus.o_counter), 32'd29);
        step(1'b1, 1'b0, "wrap");
        check("wrap_cnt",  32'(bus.o_counter), 32'd0);
        check("wrap_main", 32'(bus.o_main_light), 32'b001);
        check("wrap_pchg", 32'(bus.o_phase_chg), 32'd1);
        step(1'b0, 1'b0, "wrap_hold");
        check("wrap_pchg_clr", 32'(bus.o_phase_chg), 32'd0);

        // Pedestrian: pulse at count 5 (served this cycle), none next cycle
        // until a pulse at count 21, which is served the cycle after.
        for (int i = 0; i < 90; i++) begin
            step(1'b1, (i == 5) || (i == 51), "ped");
`ifdef TRAFFIC_PED_WALK_EN
            if (i == 19) check("ped_walk_c1", 32'(bus.o_walk), 32'd1);
            if (i == 49) check("ped_nowalk_c2", 32'(bus.o_walk), 32'd0);
            if (i == 52) check("ped_late_c2", 32'(bus.o_walk), 32'd0);
            if (i == 79) check("ped_walk_c3", 32'(bus.o_walk), 32'd1);
            if (i == 86) check("ped_walk_off", 32'(bus.o_walk), 32'd0);
`else
            if (i == 19) check("ped_ignored", 32'(bus.o_walk), 32'd0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
